// File: rtl/bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the source holds its data and valid stable
// until that edge, and ready may be high without valid.
interface bcd_seq_if #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic                  sign;

    // Producer of binary words and consumer of BCD results
    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, bcd, overflow, sign
    );

    // The converter itself
    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, bcd, overflow, sign
    );
endinterface

// File: rtl/bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// IDLE accepts a word, SHIFT runs IN_WIDTH add-3/shift steps, DONE holds the
// result until the consumer takes it. Digits that do not fit are dropped and
// flagged by overflow; the kept digits are value mod 10^DIGITS.
// Optional macro BCD_SIGNED_EN: treat in as two's complement, convert |in|
// and report the sign; without it sign is tied low.
module bcd_seq #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd_seq_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] shreg;
    logic [4*DIGITS-1:0] digits;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;
    logic                ovf_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic [IN_WIDTH-1:0] load_val;

    // Add-3 correction for every digit in parallel, from the pre-adjust values
    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            adj[4*d +: 4] = (digits[4*d +: 4] >= 4'd5) ? digits[4*d +: 4] + 4'd3
                                                       : digits[4*d +: 4];
        end
    end

`ifdef BCD_SIGNED_EN
    logic sign_q;

    // Magnitude of the two's complement word; the most negative value maps
    // to 2^(IN_WIDTH-1), which still fits as an unsigned IN_WIDTH-bit number
    always_comb begin
        load_val = bus.in[IN_WIDTH-1] ? (~bus.in + 1'b1) : bus.in;
    end

    // Sign is captured at acceptance and held with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            sign_q <= bus.in[IN_WIDTH-1];
        end
    end

    assign bus.sign = sign_q;
`else
    // Unsigned input: load the word as-is
    always_comb begin
        load_val = bus.in;
    end

    assign bus.sign = 1'b0;
`endif

    // Control FSM and datapath: accept, shift IN_WIDTH times, hold result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            digits      <= '0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg      <= load_val;
                        digits     <= '0;
                        ovf_q      <= 1'b0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits <= {adj[4*DIGITS-2:0], shreg[IN_WIDTH-1]};
                    shreg  <= {shreg[IN_WIDTH-2:0], 1'b0};
                    if (adj[4*DIGITS-1]) begin
                        ovf_q <= 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(IN_WIDTH - 1)) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.bcd       = digits;
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_bcd_seq.sv
// Directed bench for bcd_seq: a 5-digit and a 4-digit instance share one
// driver; sel picks which one is active.
module tb_bcd_seq;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    bcd_seq_if #(.IN_WIDTH(16), .DIGITS(5)) if5 ();
    bcd_seq_if #(.IN_WIDTH(16), .DIGITS(4)) if4 ();
    logic [1:0] dbg5, dbg4;

    bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave), .dbg_state(dbg5));
    bcd_seq #(.IN_WIDTH(16), .DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .dbg_state(dbg4));

    logic        sel = 1'b0;
    logic        valid_drv = 1'b0;
    logic        ready_drv = 1'b0;
    logic [15:0] in_drv = '0;

    assign if5.in_valid  = valid_drv & ~sel;
    assign if4.in_valid  = valid_drv & sel;
    assign if5.in        = in_drv;
    assign if4.in        = in_drv;
    assign if5.out_ready = ready_drv;
    assign if4.out_ready = ready_drv;

    logic [19:0] o_bcd;
    logic        o_valid, o_ready, o_ovf, o_sign;
    assign o_bcd   = sel ? {4'h0, if4.bcd} : if5.bcd;
    assign o_valid = sel ? if4.out_valid : if5.out_valid;
    assign o_ready = sel ? if4.in_ready  : if5.in_ready;
    assign o_ovf   = sel ? if4.overflow  : if5.overflow;
    assign o_sign  = sel ? if4.sign      : if5.sign;

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int last_accept = -1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Converts v on the selected instance; hold = cycles out_ready stays low
    // after out_valid rises (0 = consumer always ready).
    task automatic convert(input logic [15:0] v, input logic [19:0] eb,
                           input logic eo, input logic es, input int hold,
                           input int min_gap);
        int n;
        int busy_err;
        logic [19:0] held;
        exp_q.push_back(eb);
        ready_drv = (hold == 0);
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", o_ready, 1);
        valid_drv = 1'b1;
        in_drv    = v;
        @(posedge clk);
        if (min_gap > 0) check("accept_interval_ok", (cyc - last_accept) >= min_gap, 1);
        last_accept = cyc;
        @(negedge clk);
        valid_drv = 1'b0;
        in_drv    = 16'($urandom_range(0, 65535));
        n = 0;
        busy_err = 0;
        while (!o_valid && n < 100) begin
            if (o_ready) busy_err++;
            @(negedge clk);
            n++;
        end
        check("latency", n, 16);
        check("in_ready_low_shift", busy_err, 0);
        held = o_bcd;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (o_bcd !== held || !o_valid || o_ready) busy_err++;
        end
        check("hold_stable", busy_err, 0);
        check("bcd", o_bcd, exp_q.pop_front());
        check("overflow", o_ovf, eo);
        check("sign", o_sign, es);
        check("in_ready_done", o_ready, 0);
        ready_drv = 1'b1;
        @(negedge clk);
        check("out_valid_cleared", o_valid, 0);
        check("in_ready_back", o_ready, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", if5.in_ready, 1);
        check("rst_out_valid", if5.out_valid, 0);
        check("rst_bcd", if5.bcd, 0);
        check("rst_state", dbg5, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // full-scale 16-bit value
        convert(16'd65535, 20'h65535, 1'b0, 1'b0, 0, 0);
        // back-to-back, consumer always ready: accept interval must be >= 18
        convert(16'd0, 20'h00000, 1'b0, 1'b0, 0, 0);
        convert(16'd9, 20'h00009, 1'b0, 1'b0, 0, 18);
        // backpressure hold
        convert(16'd4096, 20'h04096, 1'b0, 1'b0, 10, 0);

        // 4-digit instance: overflow then a clean conversion
        sel = 1'b1;
        @(negedge clk);
        convert(16'd12345, 20'h02345, 1'b1, 1'b0, 0, 0);
        convert(16'd9999, 20'h09999, 1'b0, 1'b0, 0, 0);
        convert(16'd10000, 20'h00000, 1'b1, 1'b0, 0, 0);
        sel = 1'b0;
        @(negedge clk);

        // reset mid-conversion
        valid_drv = 1'b1;
        in_drv    = 16'd50000;
        @(negedge clk);
        valid_drv = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_state_shift", dbg5, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bcd", if5.bcd, 0);
        check("async_rst_ovf", if5.overflow, 0);
        check("async_rst_valid", if5.out_valid, 0);
        check("async_rst_ready", if5.in_ready, 1);
        check("async_rst_state", dbg5, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(16'd123, 20'h00123, 1'b0, 1'b0, 0, 0);

`ifdef BCD_SIGNED_EN
        convert(16'hFB2E, 20'h01234, 1'b0, 1'b1, 0, 0);  // -1234
        convert(16'h8000, 20'h32768, 1'b0, 1'b1, 0, 0);  // -32768
        convert(16'h7FFF, 20'h32767, 1'b0, 1'b0, 0, 0);  // 32767
`else
        convert(16'd32768, 20'h32768, 1'b0, 1'b0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end
endmodule
